xor_crc_engine: RTL and testbench
=================================

// Module: xor_crc_engine
// PURPOSE
//  Streaming, parametrised XOR reduction engine. Generalises the 2-input Xor gate to multi-bit words.
//  Accumulates one DATA_W word per cycle over a framed stream.
//  Returns either a plain XOR checksum (mode 0) or an MSB-first CRC (mode 1) over a valid/ready output.
//  Sits between the memory/IO word stream and the integrity-check logic.
// PARAMETERS
//  DATA_W   16       input word width, >=1
//  CRC_W    16       accumulator/result width, 1..32
//  POLY     16'h1021 CRC generator polynomial, implicit top bit omitted
//  INIT     16'hFFFF CRC seed, mode 1 only; mode 0 always seeds 0
//  XOR_OUT  16'h0000 final XOR on the CRC result, mode 1 only
//  LEN_W    8        width of the beat counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       input word valid
//  in_ready   out  1       engine accepts a word this cycle
//  in_data    in   DATA_W  input word
//  in_last    in   1       word is the final beat of the frame
//  mode       in   1       0 = XOR checksum, 1 = CRC; sampled on the first beat only
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer takes the result
//  out_crc    out  CRC_W   result
//  out_len    out  LEN_W   beats in the frame, saturating at 2^LEN_W-1
//  busy       out  1       frame in progress or result pending
// BEHAVIOUR
//  - Reset: async assert, sync release. Outputs: out_valid=0, out_crc=0, out_len=0, busy=0; state IDLE.
//    in_ready is combinational from state, so it is 1 once in IDLE.
//  - Accept occurs when in_valid & in_ready. One word per cycle; no bubbles required.
//  - FSM IDLE -> ACCUM -> DONE:
//    - IDLE (in_ready=1): accepting latches mode, seeds acc (INIT or 0), folds the word, len=1.
//      last=1 -> DONE, otherwise -> ACCUM.
//    - ACCUM (in_ready=1): each accept folds the word and increments len.
//      Accept with last=1 -> DONE.
//    - DONE (in_ready=0, out_valid=1): out_crc/out_len held stable until out_ready=1.
//      Then -> IDLE with out_valid=0 on the next cycle.
//  - Latency: out_valid rises on the cycle after the last beat is accepted.
//    The next frame's first beat is accepted no earlier than the cycle after the output handshake.
//  - Mode 0 fold: acc ^= in_data, with in_data zero-extended or truncated (LSBs kept) to CRC_W.
//  - Mode 1 fold: DATA_W bit-steps unrolled combinationally, taking in_data MSB first.
//    Per bit: fb = acc[CRC_W-1] ^ d; acc = {acc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
//  - Result: mode 1 -> acc ^ XOR_OUT; mode 0 -> acc.
//  - mode changes mid-frame are ignored; the latched value governs the whole frame.
//  - in_data/in_last are don't-care when in_valid=0. No state change without an accept.
//  - out_len saturates and does not wrap. The frame still completes normally.
//  - busy = (state != IDLE).
//  - rst_n low mid-frame or in DONE discards the frame and the result; no output is produced.
//  - in_valid held high during DONE is back-pressured; the word is taken once IDLE is reached.
// STRUCTURE
//  - Shared package: state encoding (IDLE/ACCUM/DONE), MODE_XOR/MODE_CRC constants,
//    and the default CRC-16/CCITT-FALSE constants (POLY, INIT, XOR_OUT).
//  - One sub-module, crc_step: combinational single-word fold.
//    Parameters DATA_W, CRC_W, POLY. Inputs acc, data, mode; output next_acc.
//  - Top level holds the FSM, registers and counter.
// TESTING
//  1. Mode 1, DATA_W=8 instance: ASCII "123456789" (0x31..0x39) back-to-back, last on 0x39
//     -> out_crc=0x29B1, out_len=9, out_valid one cycle after the last accept.
//  2. Mode 0, DATA_W=16: 0x1234, 0x00FF, 0xF0F0 (last) -> out_crc=0xE23B, out_len=3.
//  3. Back-pressure: hold out_ready=0 for 5 cycles -> in_ready=0 and out_crc stable throughout.
//     Then out_ready=1 -> IDLE next cycle; a queued in_valid word is accepted the cycle after.
//  4. Gaps and mode toggling: test-1 bytes with in_valid low every other cycle,
//     and mode toggled mid-frame -> result still 0x29B1.
//  5. Reset mid-frame: assert rst_n=0 after 4 bytes -> outputs zero immediately.
//     Then a fresh "123456789" frame -> 0x29B1.
//  6. Single-beat frame: mode 0, 0xA5A5 with last -> out_crc=0xA5A5, out_len=1.
//     LEN_W=2 instance with a 6-beat frame -> out_len=3 (saturated).

Source files
------------

// File: rtl/xor_crc_engine_pkg.sv
// Shared definitions for the streaming XOR/CRC engine: FSM encoding, mode
// codes and the default CRC-16/CCITT-FALSE constants.
package xor_crc_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_XOR = 1'b0;
    localparam logic MODE_CRC = 1'b1;

    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_XOR_OUT = 16'h0000;

endpackage

// File: rtl/xor_crc_engine_crc_step.sv
// Combinational single-word fold: XOR accumulate or an MSB-first CRC update
// with all DATA_W bit steps unrolled.
module crc_step
    import xor_crc_engine_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter int                CRC_W  = 16,
    parameter logic [CRC_W-1:0]  POLY   = CRC_W'(CRC16_POLY)
) (
    input  logic [CRC_W-1:0]  acc,
    input  logic [DATA_W-1:0] data,
    input  logic              mode,
    output logic [CRC_W-1:0]  next_acc
);

    logic [CRC_W-1:0] crc;
    logic             fb;

    always_comb begin
        crc = acc;
        fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb  = crc[CRC_W-1] ^ data[i];
            crc = (crc << 1) ^ (fb ? POLY : '0);
        end
        // Size cast zero-extends narrow words and keeps the LSBs of wide ones.
        if (mode == MODE_CRC) begin
            next_acc = crc;
        end else begin
            next_acc = acc ^ CRC_W'(data);
        end
    end

endmodule

// File: rtl/xor_crc_engine.sv
// Framed XOR-checksum / CRC engine: folds one word per accepted beat and
// presents the result and beat count over a valid/ready output.
module xor_crc_engine
    import xor_crc_engine_pkg::*;
#(
    parameter int                DATA_W  = 16,
    parameter int                CRC_W   = 16,
    parameter logic [CRC_W-1:0]  POLY    = CRC_W'(CRC16_POLY),
    parameter logic [CRC_W-1:0]  INIT    = CRC_W'(CRC16_INIT),
    parameter logic [CRC_W-1:0]  XOR_OUT = CRC_W'(CRC16_XOR_OUT),
    parameter int                LEN_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc,
    output logic [LEN_W-1:0]  out_len,
    output logic              busy
);

    state_t           state, next_state;
    logic             mode_q;
    logic             frame_mode;
    logic             accept;
    logic [CRC_W-1:0] acc, seed, next_acc, res;
    logic [LEN_W-1:0] len, len_next;

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;
    assign out_crc   = res;
    assign out_len   = len;

    // The first beat uses the live mode and a fresh seed; later beats use the latched frame state.
    assign frame_mode = (state == IDLE) ? mode : mode_q;
    assign seed       = (state == IDLE) ? ((mode == MODE_CRC) ? INIT : '0) : acc;
    assign len_next   = (state == IDLE) ? LEN_W'(1) : ((&len) ? len : len + 1'b1);

    crc_step #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_crc_step (
        .acc      (seed),
        .data     (in_data),
        .mode     (frame_mode),
        .next_acc (next_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    next_state = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            res    <= '0;
            len    <= '0;
            mode_q <= MODE_XOR;
        end else if (accept) begin
            acc <= next_acc;
            len <= len_next;
            if (state == IDLE) begin
                mode_q <= mode;
            end
            if (in_last) begin
                res <= (frame_mode == MODE_CRC) ? (next_acc ^ XOR_OUT) : next_acc;
            end
        end
    end

endmodule

// File: tb/tb_xor_crc_engine.sv
// Drives three engine instances (8-bit data, 16-bit data, 2-bit length) from one
// shared stream and checks each against a bit-serial reference model.
module tb_xor_crc_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        mode = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic [7:0]  in_byte;
    assign in_byte = in_data[7:0];

    logic        rdy8, ov8, busy8;
    logic [15:0] crc8;
    logic [7:0]  len8;
    logic        rdy16, ov16, busy16;
    logic [15:0] crc16;
    logic [7:0]  len16;
    logic        rdys, ovs, busys;
    logic [15:0] crcs;
    logic [1:0]  lens;

    xor_crc_engine #(.DATA_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .in_data(in_byte),
        .in_last(in_last), .mode(mode), .out_valid(ov8), .out_ready(out_ready),
        .out_crc(crc8), .out_len(len8), .busy(busy8));

    xor_crc_engine u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16), .in_data(in_data),
        .in_last(in_last), .mode(mode), .out_valid(ov16), .out_ready(out_ready),
        .out_crc(crc16), .out_len(len16), .busy(busy16));

    xor_crc_engine #(.LEN_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdys), .in_data(in_data),
        .in_last(in_last), .mode(mode), .out_valid(ovs), .out_ready(out_ready),
        .out_crc(crcs), .out_len(lens), .busy(busys));

    int          total = 0;
    int          bad = 0;
    logic [15:0] frame_q[$];
    logic        frame_mode = 1'b0;
    logic [15:0] exp16;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mode 0: XOR of all words; mode 1: CRC over the concatenated MSB-first bit stream.
    function automatic logic [15:0] model_crc(input int w);
        logic [15:0] r;
        logic [15:0] wd;
        logic        top;
        bit          bits[$];
        if (frame_mode == 1'b0) begin
            r = 16'h0;
            foreach (frame_q[i]) r ^= (w == 8) ? (frame_q[i] & 16'h00FF) : frame_q[i];
            return r;
        end
        foreach (frame_q[i]) begin
            wd = frame_q[i];
            for (int b = w - 1; b >= 0; b--) bits.push_back(wd[b]);
        end
        r = 16'hFFFF;
        foreach (bits[k]) begin
            top = r[15] ^ bits[k];
            r = r << 1;
            if (top) r ^= 16'h1021;
        end
        return r ^ 16'h0000;
    endfunction

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    // Tasks start and end at posedge+1.
    task automatic send_word(input logic [15:0] d, input logic last, input logic m, input int gap);
        int waited;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        mode = m;
        waited = 0;
        while (!rdy16 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!rdy16) check("in_ready_timeout", 32'd0, 32'd1);
        if (frame_q.size() == 0) frame_mode = m;
        frame_q.push_back(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = 16'($urandom);
        mode = 1'($urandom);
    endtask

    task automatic check_result(input string tag);
        int n;
        n = frame_q.size();
        check({tag, "_valid16"}, ov16, 1);
        check({tag, "_valid8"}, ov8, 1);
        check({tag, "_crc8"}, crc8, model_crc(8));
        check({tag, "_crc16"}, crc16, model_crc(16));
        check({tag, "_crc_sat"}, crcs, model_crc(16));
        check({tag, "_len8"}, len8, sat(n, 255));
        check({tag, "_len16"}, len16, sat(n, 255));
        check({tag, "_len_sat"}, lens, sat(n, 3));
    endtask

    task automatic handshake(input string tag, input int delay);
        exp16 = model_crc(16);
        out_ready = 1'b0;
        for (int c = 0; c < delay; c++) begin
            @(posedge clk); #1;
            check({tag, "_hold_ready"}, rdy16, 0);
            check({tag, "_hold_crc"}, crc16, exp16);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release_valid"}, ov16, 0);
        check({tag, "_release_busy"}, busy16, 0);
        frame_q.delete();
    endtask

    task automatic send_count_frame(input logic m, input int gap, input bit toggle);
        logic [15:0] b;
        for (int i = 0; i < 9; i++) begin
            b = 16'h0031 + 16'(i);
            send_word(b, (i == 8), toggle ? ((i % 2) == 0) : m, gap);
            if (i < 8) check("count_frame_no_early_valid", ov16, 0);
        end
    endtask

    initial begin
        int n;
        logic m;
        #1;
        check("reset_valid", ov16, 0);
        check("reset_crc", crc16, 0);
        check("reset_len", len16, 0);
        check("reset_busy", busy16, 0);
        check("reset_ready", rdy16, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Check string "123456789", back-to-back.
        send_count_frame(1'b1, 0, 1'b0);
        check_result("t1");
        check("t1_known_crc", crc8, 16'h29B1);
        check("t1_known_len", len8, 9);
        handshake("t1", 0);

        // XOR checksum.
        send_word(16'h1234, 1'b0, 1'b0, 0);
        send_word(16'h00FF, 1'b0, 1'b0, 0);
        send_word(16'hF0F0, 1'b1, 1'b0, 0);
        check_result("t2");
        check("t2_known_crc", crc16, 16'hE23B);
        handshake("t2", 0);

        // Back-pressure with a queued word waiting.
        for (int i = 0; i < 3; i++) send_word(16'($urandom), (i == 2), 1'b1, 0);
        check_result("t3");
        exp16 = model_crc(16);
        in_valid = 1'b1;
        in_data = 16'hBEEF;
        in_last = 1'b1;
        mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("t3_bp_ready", rdy16, 0);
            check("t3_bp_crc", crc16, exp16);
            check("t3_bp_valid", ov16, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t3_idle_valid", ov16, 0);
        check("t3_idle_ready", rdy16, 1);
        check("t3_idle_busy", busy16, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        frame_q.delete();
        frame_q.push_back(16'hBEEF);
        frame_mode = 1'b0;
        check_result("t3_queued");
        handshake("t3q", 0);

        // Gaps and mid-frame mode toggling.
        send_count_frame(1'b1, 1, 1'b1);
        check_result("t4");
        check("t4_known_crc", crc8, 16'h29B1);
        handshake("t4", 2);

        // Reset mid-frame.
        for (int i = 0; i < 4; i++) send_word(16'h0031 + 16'(i), 1'b0, 1'b1, 0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", ov16, 0);
        check("t5_rst_crc", crc16, 0);
        check("t5_rst_len", len16, 0);
        check("t5_rst_busy", busy16, 0);
        check("t5_rst_crc8", crc8, 0);
        frame_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_count_frame(1'b1, 0, 1'b0);
        check_result("t5");
        check("t5_known_crc", crc8, 16'h29B1);
        handshake("t5", 1);

        // Single beat and length saturation.
        send_word(16'hA5A5, 1'b1, 1'b0, 0);
        check_result("t6a");
        check("t6_known_crc", crc16, 16'hA5A5);
        check("t6_known_len", len16, 1);
        handshake("t6a", 0);
        for (int i = 0; i < 6; i++) send_word(16'($urandom), (i == 5), 1'b1, 0);
        check_result("t6b");
        check("t6_sat_len", lens, 3);
        handshake("t6b", 0);

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(1, 12);
            m = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                send_word(16'($urandom), (i == n - 1), (i == 0) ? m : 1'($urandom), $urandom_range(0, 2));
            end
            check_result("rand");
            handshake("rand", $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        check("global_timeout", 32'd0, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
